// File: rtl/toggle_cover_pkg.sv
// Shared types and helpers for the per-bit toggle coverage tracker.
package toggle_cover_pkg;

  typedef enum logic [1:0] {
    NONE      = 2'b00,
    RISE_ONLY = 2'b01,
    FALL_ONLY = 2'b10,
    BOTH      = 2'b11
  } tgl_state_t;

  // Widest vector popcount accepts; narrower callers zero-extend into it.
  localparam int POP_MAX_W = 1024;
  localparam int POP_OUT_W = $clog2(POP_MAX_W + 1);

  function automatic logic [POP_OUT_W-1:0] popcount(input logic [POP_MAX_W-1:0] v);
    logic [POP_OUT_W-1:0] n;
    n = '0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n = n + POP_OUT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/toggle_cover_bit.sv
// Per-bit toggle FSM: tracks whether a rise and a fall have both been seen.
module toggle_cover_bit
  import toggle_cover_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic rise,
  input  logic fall,
  input  logic clear,
  output logic covered,
  output logic newly
);

  tgl_state_t state, state_nxt;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state <= NONE;
    end else begin
      state <= state_nxt;
    end
  end

  // newly marks the edge that moves the bit into BOTH; a same-edge clear suppresses it
  always_comb begin
    state_nxt = state;
    newly     = 1'b0;
    case (state)
      NONE: begin
        if (rise) begin
          state_nxt = RISE_ONLY;
        end else if (fall) begin
          state_nxt = FALL_ONLY;
        end
      end
      RISE_ONLY: begin
        if (fall) begin
          state_nxt = BOTH;
          newly     = ~clear;
        end
      end
      FALL_ONLY: begin
        if (rise) begin
          state_nxt = BOTH;
          newly     = ~clear;
        end
      end
      BOTH: begin
        state_nxt = BOTH;
      end
    endcase
  end

  assign covered = (state == BOTH);

endmodule

// File: rtl/toggle_cover_tracker.sv
// Watches an N-bit signal and reports, per bit, the first time both a rise and a fall
// have been observed, plus a running count of covered bits.
module toggle_cover_tracker
  import toggle_cover_pkg::*;
#(
  parameter int WIDTH = 37,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] signal,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] valid,
  output logic [WIDTH-1:0] covered,
  output logic [CNT_W-1:0] cover_count,
  output logic             all_covered
);

  generate
    if (WIDTH < 1 || WIDTH > POP_MAX_W) begin : g_bad_width
      $error("toggle_cover_tracker: WIDTH out of supported range");
    end
  endgenerate

  logic [WIDTH-1:0] prev_p0;
  logic             armed_p0;
  logic             edge_en;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] newly;
  logic [CNT_W-1:0] count_nxt;
  logic [WIDTH-1:0] valid_p1;
  logic [CNT_W-1:0] count_p1;
  logic             all_p1;

  // Stage 0: edge detection against the baseline, only once the baseline is armed
  assign edge_en = enable & armed_p0 & ~clear;
  assign rise    = edge_en ? (~prev_p0 & signal) : '0;
  assign fall    = edge_en ? (prev_p0 & ~signal) : '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    toggle_cover_bit u_bit (
      .clock   (clock),
      .reset   (reset),
      .rise    (rise[i]),
      .fall    (fall[i]),
      .clear   (clear),
      .covered (covered[i]),
      .newly   (newly[i])
    );
  end

  assign count_nxt = cover_count + CNT_W'(popcount(POP_MAX_W'(newly)));

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_p0  <= '0;
      armed_p0 <= 1'b0;
    end else if (clear || !enable) begin
      armed_p0 <= 1'b0;
    end else begin
      prev_p0  <= signal;
      armed_p0 <= 1'b1;
    end
  end

  // Stage 1: registered pulse, count and full-coverage flag
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      valid_p1 <= '0;
      count_p1 <= '0;
      all_p1   <= 1'b0;
    end else begin
      valid_p1 <= newly;
      count_p1 <= count_nxt;
      all_p1   <= (count_nxt == CNT_W'(WIDTH));
    end
  end

  assign valid       = valid_p1;
  assign cover_count = count_p1;
  assign all_covered = all_p1;

endmodule

// File: doc/toggle_cover_tracker.md
# toggle_cover_tracker

Per-bit toggle detector that feeds the `GEN_w<N>_toggle` coverage reporters. It watches an N-bit design signal and records, per bit, whether both a rising and a falling transition have been seen. On the cycle a bit first completes both, it emits a one-cycle `valid` pulse, which is wired straight into the reporter's `valid` input. It also keeps a running covered-bit count for coverage-closure monitoring and for formal cover targets.

## Interface
- `WIDTH`, default 37: number of monitored bits; must be ≥ 1.
- `CNT_W`, default `$clog2(WIDTH+1)` (6 for 37): width of the covered-bit counter.

Ports:
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `signal`  in  WIDTH: monitored design signal, sampled every `clock` edge.
- `enable`  in  1: sampling enable; low means no detection.
- `clear`  in  1: synchronous coverage wipe without a full reset.
- `valid`  out  WIDTH: one-cycle pulse per bit on first completion; connects to the reporter's `valid`.
- `covered`  out  WIDTH: sticky; bit set once both edges have been seen.
- `cover_count`  out  CNT_W: number of set `covered` bits.
- `all_covered`  out  1: `cover_count == WIDTH`.

## Operation
- **Baseline register and `armed` flag.**
  - `prev` (WIDTH bits) and `armed` (1 bit).
  - An enabled edge with `armed=0` only loads `prev <= signal` and sets `armed`. No edge is credited on that edge.
  - `enable=0`: clears `armed` and holds `prev`. Transitions that happen while disabled are never credited, so re-enabling re-baselines.
- **Edge detection.** On an edge with `enable & armed & ~clear`:
  - `rise = ~prev & signal`
  - `fall = prev & ~signal`
  - then `prev <= signal`.
- **Per-bit FSM** (2-bit state):
  - NONE → RISE_ONLY on rise, and NONE → FALL_ONLY on fall.
  - RISE_ONLY → BOTH on fall; FALL_ONLY → BOTH on rise.
  - BOTH is absorbing until `clear` or `reset`.
- **Outputs.**
  - `covered[i]` is 1 exactly when state == BOTH.
  - `valid[i]` is registered. It is 1 for exactly one cycle after the edge that moves bit i into BOTH, and never again until coverage is cleared.
- **Counter.**
  - `cover_count <= cover_count + popcount(newly_covered)`, where `newly_covered` is the set of bits entering BOTH on that edge.
  - Multiple bits completing on one edge are all added on that edge.
  - The counter cannot overflow, because its maximum value is WIDTH.
- **`all_covered`** is registered, computed from the next count on the same edge as the count update.
- **`clear` (high on an edge).**
  - Returns all FSMs to NONE and zeroes `valid`, `cover_count`, `all_covered` and `armed`.
  - `clear` wins over a same-edge completion: no pulse is produced and nothing is counted.
- **Reset** does the same as `clear`, and additionally zeroes `prev`. It takes priority over everything. Reset mid-operation discards all progress.

## Timing
- Reset values: `valid=0`, `covered=0`, `cover_count=0`, `all_covered=0`, internal `armed=0`, `prev=0`, all FSMs NONE.
- Latency: a completing transition sampled at edge k gives `valid`, `covered`, `cover_count` and `all_covered` updated and visible after edge k.
- The first edge that can credit a transition is the second consecutive enabled edge after reset, `clear`, or `enable` falling.
- `valid` is never high for two consecutive cycles on the same bit.
- There is no backpressure. The consumer samples `valid` on every edge.

## Structure
- Shared package `toggle_cover_pkg`:
  - 2-bit typedef `tgl_state_t` with values NONE, RISE_ONLY, FALL_ONLY, BOTH;
  - parameterised popcount function.
- Sub-module `toggle_cover_bit`:
  - per-bit FSM with inputs `rise`, `fall`, `clear`;
  - outputs `covered` and `newly`;
  - instantiated WIDTH times with a generate loop.
- Top level holds `prev`, `armed`, the counter and the output registers.

## Test plan
1. **Quiet signal:** reset, then `enable=1`, `signal=0` held for 10 cycles → `valid=0`, `cover_count=0`, `all_covered=0` throughout.
2. **Single-bit completion:** `signal[3]` 0→1 at edge 3, 1→0 at edge 6 →
   - `valid[3]` high only in the cycle after edge 6;
   - `covered[3]=1`, `cover_count=1`;
   - three further toggles of bit 3 produce no pulse and the count stays 1.
3. **Baseline and full width:** `signal` = all-ones on the first enabled edge after reset (no credit), then all-zeros, then all-ones →
   - after the falls: `covered=0`;
   - after the rises: `valid=37'h1F_FFFF_FFFF` for one cycle, `cover_count=37`, `all_covered=1`.
4. **Clear collision:** bit 0 already in RISE_ONLY; `clear=1` on the same edge as its fall →
   - no `valid[0]`, `cover_count=0`;
   - a rise on the following edge is not credited (re-baseline).
5. **Disabled transition:** `enable=0`, bit 5 rises, then `enable=1` for 2 cycles with bit 5 held high → no rise credited; bit 5 stays in NONE.
6. **Reset mid-run:** `cover_count=4`, then `reset` for 1 cycle → all outputs 0 on the next cycle, and prior `covered` bits are lost.
